// File: rtl/dflipflop_exerciser_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dflipflop_exerciser_pkg
// Brief    : Shared types, constants and LFSR step function for the
//            D flip-flop exerciser.
// Revision : 1.0 - initial release
// ============================================================================
package dflipflop_exerciser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        HIGH   = 3'd2,
        LOWCHK = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Bit k-1 set for each polynomial term x^k of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] c_lfsr_taps = 8'hB8;
    localparam logic [4:0] c_err_max   = 5'd31;
    localparam int         c_phase_w   = 8;

    // Shifting toward bit 0, term x^k feeds back from stage 8-k
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fb = fb ^ (s[k] & c_lfsr_taps[7-k]);
        end
        return {fb, s[7:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dflipflop_exerciser_lfsr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dflipflop_exerciser_lfsr
// Brief    : 8-bit Fibonacci LFSR with seed load and single-step advance.
// Revision : 1.0 - initial release
// ============================================================================
module dflipflop_exerciser_lfsr
    import dflipflop_exerciser_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_advance,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_state <= SEED;
        end else if (i_advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/dflipflop_exerciser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dflipflop_exerciser
// Brief    : Drives a prescaled clock and pseudo-random data into a falling-
//            edge D flip-flop and counts mismatches on its returned Q.
// Revision : 1.0 - initial release
// ============================================================================
module dflipflop_exerciser
    import dflipflop_exerciser_pkg::*;
#(
    parameter int         PRESCALE  = 8,
    parameter int         N_VECTORS = 16,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       input_clock1_clk_1,
    input  logic       input_push_button2_rst_2,
    input  logic       start,
    input  logic       dut_q,
    output logic       dut_clk,
    output logic       dut_d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count
);

    localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(PRESCALE - 1);
    localparam logic [7:0]           c_vec_total  = 8'(N_VECTORS);

    state_e               r_state;
    state_e               w_state_next;
    logic [c_phase_w-1:0] r_phase;
    logic [7:0]           r_vec;
    logic [4:0]           r_err;
    logic                 r_q_meta;
    logic                 r_q_sync;
    logic [7:0]           w_lfsr;
    logic                 w_busy;
    logic                 w_phase_last;
    logic                 w_start_ok;
    logic                 w_vec_end;
    logic [7:0]           w_vec_next;

    assign w_busy       = (r_state == SETUP) || (r_state == HIGH) || (r_state == LOWCHK);
    assign w_phase_last = (r_phase == c_phase_last);
    assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_vec_end    = (r_state == LOWCHK) && w_phase_last;
    assign w_vec_next   = r_vec + 8'd1;

    // Two-flop synchronizer; PRESCALE >= 3 keeps the compare past its latency
    always_ff @(posedge input_clock1_clk_1) begin
        if (input_push_button2_rst_2) begin
            r_q_meta <= 1'b0;
            r_q_sync <= 1'b0;
        end else begin
            r_q_meta <= dut_q;
            r_q_sync <= r_q_meta;
        end
    end

    always_ff @(posedge input_clock1_clk_1) begin
        if (input_push_button2_rst_2) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_next = SETUP;
            SETUP:      if (w_phase_last) w_state_next = HIGH;
            HIGH:       if (w_phase_last) w_state_next = LOWCHK;
            LOWCHK: begin
                if (w_phase_last) begin
                    w_state_next = (w_vec_next == c_vec_total) ? DONE : SETUP;
                end
            end
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge input_clock1_clk_1) begin
        if (input_push_button2_rst_2 || (w_state_next != r_state)) begin
            r_phase <= '0;
        end else if (w_busy) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge input_clock1_clk_1) begin
        if (input_push_button2_rst_2 || w_start_ok) begin
            r_vec <= 8'd0;
            r_err <= 5'd0;
        end else if (w_vec_end) begin
            r_vec <= w_vec_next;
            if ((r_q_sync != w_lfsr[0]) && (r_err != c_err_max)) begin
                r_err <= r_err + 5'd1;
            end
        end
    end

    // LFSR stays constant for a whole vector, so bit 0 is the held dut_d
    dflipflop_exerciser_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (input_clock1_clk_1),
        .rst       (input_push_button2_rst_2),
        .i_load    (w_start_ok),
        .i_advance (w_vec_end),
        .o_state   (w_lfsr)
    );

    always_comb begin
        dut_clk   = 1'b0;
        dut_d     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        err_count = r_err;
        case (r_state)
            SETUP, LOWCHK: begin
                busy  = 1'b1;
                dut_d = w_lfsr[0];
            end
            HIGH: begin
                busy    = 1'b1;
                dut_clk = 1'b1;
                dut_d   = w_lfsr[0];
            end
            DONE: begin
                done = 1'b1;
                pass = (r_err == 5'd0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
